// File: rtl/soc_pio_ext_if.sv
// Avalon-MM slave bundle for soc_pio_ext: 3-bit word address, 32-bit data,
// fixed one-cycle read latency.
interface soc_pio_ext_if;
  logic [2:0]  avs_address;
  logic        avs_read;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic [31:0] avs_readdata;

  modport master (
    output avs_address, avs_read, avs_write, avs_writedata,
    input  avs_readdata
  );

  modport slave (
    input  avs_address, avs_read, avs_write, avs_writedata,
    output avs_readdata
  );
endinterface

// File: rtl/soc_pio_ext.sv
// Parallel I/O with synchronised, optionally debounced inputs, edge capture and level irq.
// Define PIO_DEBOUNCE_EN to build the tick-sampled debouncer; otherwise inputs are only synchronised.
module soc_pio_ext #(
  parameter int WIDTH           = 10,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int EDGE_MODE       = 0
) (
  input  logic             clk_clk,
  input  logic             reset_reset,
  soc_pio_ext_if.slave     avs,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] out_port,
  output logic             irq
);

  typedef enum logic [2:0] {
    REG_DATA    = 3'd0,
    REG_OUTSET  = 3'd1,
    REG_OUTCLR  = 3'd2,
    REG_IRQMASK = 3'd3,
    REG_EDGECAP = 3'd4,
    REG_OUT     = 3'd5
  } reg_addr_e;

  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $error("soc_pio_ext: WIDTH must be 1..32");
  end
  if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > (1 << 24)) begin : g_bad_debounce
    $error("soc_pio_ext: DEBOUNCE_CYCLES must be 2..2^24");
  end
  if (EDGE_MODE < 0 || EDGE_MODE > 2) begin : g_bad_edge_mode
    $error("soc_pio_ext: EDGE_MODE must be 0, 1 or 2");
  end

  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;
  logic [WIDTH-1:0] w_deb;
  logic [WIDTH-1:0] r_deb_d;
  logic [WIDTH-1:0] w_edge;
  logic [WIDTH-1:0] r_out;
  logic [WIDTH-1:0] r_mask;
  logic [WIDTH-1:0] r_edgecap;
  logic [WIDTH-1:0] w_wdata;
  logic [WIDTH-1:0] w_w1c;
  logic             r_irq;
  logic [31:0]      r_rdata;
  logic [31:0]      w_rdata_next;

  // Two-flop synchroniser; nothing downstream ever sees raw in_port.
  always_ff @(posedge clk_clk) begin
    // NOTE: registers always take non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours, exactly like hardware.
    if (reset_reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= in_port;
      r_sync2 <= r_sync1;
    end
  end

`ifdef PIO_DEBOUNCE_EN
  localparam int                 PRESC_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(DEBOUNCE_CYCLES - 1);

  logic [PRESC_W-1:0] r_presc;
  logic               w_tick;
  logic [WIDTH-1:0]   r_sample;
  logic [WIDTH-1:0]   r_deb;
  logic [WIDTH-1:0]   w_agree;

  assign w_tick  = (r_presc == PRESC_LAST);
  assign w_agree = ~(r_sync2 ^ r_sample);

  // A bit only moves after two consecutive tick samples agree, so any glitch
  // shorter than one tick period is seen by at most one sample.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      r_presc  <= '0;
      r_sample <= '0;
      r_deb    <= '0;
    end else begin
      r_presc <= w_tick ? '0 : r_presc + 1'b1;
      if (w_tick) begin
        r_sample <= r_sync2;
        r_deb    <= (w_agree & r_sync2) | (~w_agree & r_deb);
      end
    end
  end

  assign w_deb = r_deb;
`else
  assign w_deb = r_sync2;
`endif

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path
    // through the case leaves it unassigned and no latch is inferred.
    w_edge = '0;
    case (EDGE_MODE)
      1:       w_edge = ~w_deb & r_deb_d;
      2:       w_edge = w_deb ^ r_deb_d;
      default: w_edge = w_deb & ~r_deb_d;
    endcase
  end

  assign w_wdata = avs.avs_writedata[WIDTH-1:0];
  assign w_w1c   = (avs.avs_write && avs.avs_address == REG_EDGECAP) ? w_wdata : '0;

  if (WIDTH < 32) begin : g_unused_wdata
    logic w_unused_wdata;
    assign w_unused_wdata = ^avs.avs_writedata[31:WIDTH];
  end

  always_comb begin
    w_rdata_next = '0;
    case (avs.avs_address)
      REG_DATA:    w_rdata_next = 32'(w_deb);
      REG_IRQMASK: w_rdata_next = 32'(r_mask);
      REG_EDGECAP: w_rdata_next = 32'(r_edgecap);
      REG_OUT:     w_rdata_next = 32'(r_out);
      default:     w_rdata_next = '0;
    endcase
  end

  // Edge set is OR-ed after the W1C mask so a same-cycle edge survives a clear.
  // Reset forces r_deb_d to match the cleared debounced value, so no edge fires
  // in the first cycle after reset.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      r_deb_d   <= '0;
      r_out     <= '0;
      r_mask    <= '0;
      r_edgecap <= '0;
      r_irq     <= 1'b0;
      r_rdata   <= '0;
    end else begin
      r_deb_d   <= w_deb;
      r_edgecap <= (r_edgecap & ~w_w1c) | w_edge;
      r_irq     <= |(r_edgecap & r_mask);
      if (avs.avs_write) begin
        case (avs.avs_address)
          REG_DATA:    r_out  <= w_wdata;
          REG_OUTSET:  r_out  <= r_out | w_wdata;
          REG_OUTCLR:  r_out  <= r_out & ~w_wdata;
          REG_IRQMASK: r_mask <= w_wdata;
          default:     ;
        endcase
      end
      if (avs.avs_read) begin
        r_rdata <= w_rdata_next;
      end
    end
  end

  assign avs.avs_readdata = r_rdata;
  assign out_port         = r_out;
  assign irq              = r_irq;

endmodule
